decode_stage: RTL and testbench

- Registered instruction-decode stage between fetch and execute in the miniRV core.
- Accepts one instruction word plus PC per valid/ready handshake and emits decoded fields: fully sign-extended, format-correct XLEN immediate, format tag, operand-use flags and illegal-instruction flag.
- Parametrised for RV32/RV64 base opcodes and an optional skid buffer.
- Supports pipeline flush from branch resolution.

---
 rtl/decode_stage.sv | 236 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Registered instruction-decode stage sitting between fetch and execute.
//   One instruction word plus PC is accepted per in_valid/in_ready handshake.
//   It is decoded combinationally into a fully sign-extended immediate, a
//   format tag, operand-use flags and an illegal flag. The result is registered
//   and presented one cycle later on out_* with an out_valid/out_ready
//   handshake.
//
// Parameters
//   XLEN        datapath / immediate width (32 or 64)
//   ENABLE_RV64 1: OP-32 / OP-IMM-32 decode as R / I; 0: they are illegal
//   SKID        1: one-entry skid buffer, in_ready is a flop output
//               0: single output register, in_ready = !out_valid || out_ready
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             drop everything held plus any input handshaking now
//   in_valid/in_ready fetch-side handshake; in_instr, in_pc payload
//   out_valid/out_ready execute-side handshake
//   out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
//   out_imm, out_fmt, out_use_rs1, out_use_rs2, out_use_rd, out_illegal
//                     decoded fields, held stable while stalled
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN        = 32,
  parameter bit ENABLE_RV64 = 1'b0,
  parameter bit SKID        = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_use_rs1,
  output logic            out_use_rs2,
  output logic            out_use_rd,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32 or 64");
  end

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            use_rs1;
    logic            use_rs2;
    logic            use_rd;
    logic            illegal;
  } dec_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [6:0]         opcode;
  fmt_e               fmt;
  logic               uses_rd, uses_rs1, uses_rs2;
  logic signed [31:0] imm32;
  dec_t               dec;

  assign opcode = in_instr[6:0];

  always_comb begin
    fmt = FMT_NONE;
    case (opcode)
      OPC_OP:                                     fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
      OPC_STORE:                                  fmt = FMT_S;
      OPC_BRANCH:                                 fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
      OPC_JAL:                                    fmt = FMT_J;
      OPC_OP_32:     fmt = ENABLE_RV64 ? FMT_R : FMT_NONE;
      OPC_OP_IMM_32: fmt = ENABLE_RV64 ? FMT_I : FMT_NONE;
      default:       fmt = FMT_NONE;
    endcase
    // Compressed-space / non-32-bit encodings are never accepted.
    if (in_instr[1:0] != 2'b11) fmt = FMT_NONE;
  end

  always_comb begin
    uses_rd  = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
    uses_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    uses_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};

    // Every immediate is first built as a signed 32-bit value; the XLEN cast
    // below then sign-extends it, which gives the RV64 U-type its upper ones.
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U: imm32 = {in_instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    dec         = '0;
    dec.pc      = in_pc;
    dec.opcode  = opcode;
    dec.fmt     = fmt;
    dec.illegal = (fmt == FMT_NONE);
    dec.rd      = uses_rd  ? in_instr[11:7]  : 5'd0;
    dec.rs1     = uses_rs1 ? in_instr[19:15] : 5'd0;
    dec.rs2     = uses_rs2 ? in_instr[24:20] : 5'd0;
    // funct3 exists in exactly the formats that read rs1.
    dec.funct3  = uses_rs1 ? in_instr[14:12] : 3'd0;
    dec.funct7  = (fmt == FMT_R) ? in_instr[31:25] : 7'd0;
    dec.imm     = XLEN'(imm32);
    dec.use_rs1 = uses_rs1;
    dec.use_rs2 = uses_rs2;
    // Writes to x0 are architecturally dropped, so don't request writeback.
    dec.use_rd  = uses_rd && (in_instr[11:7] != 5'd0);
  end

  // ---------------------------------------------------------------------------
  // Output register and optional skid entry
  // ---------------------------------------------------------------------------
  dec_t out_q;
  logic out_valid_q;
  logic in_fire;

  assign in_fire = in_valid && in_ready;

  if (SKID) begin : g_skid
    dec_t skid_q;
    logic skid_valid_q;

    // in_ready depends only on a flop, breaking the out_ready -> in_ready path.
    // The skid entry can only fill while the output is stalled, so
    // skid_valid_q implies out_valid_q.
    assign in_ready = !skid_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q        <= '0;
        out_valid_q  <= 1'b0;
        skid_q       <= '0;
        skid_valid_q <= 1'b0;
      end else if (flush) begin
        out_valid_q  <= 1'b0;
        skid_valid_q <= 1'b0;
      end else if (!out_valid_q || out_ready) begin
        // Output slot frees up: the older skid entry has priority. While the
        // skid is full in_ready is low, so no new word competes with it.
        if (skid_valid_q) begin
          out_q        <= skid_q;
          out_valid_q  <= 1'b1;
          skid_valid_q <= 1'b0;
        end else begin
          out_valid_q <= in_fire;
          if (in_fire) out_q <= dec;
        end
      end else if (in_fire) begin
        skid_q       <= dec;
        skid_valid_q <= 1'b1;
      end
    end
  end else begin : g_noskid
    assign in_ready = !out_valid_q || out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end else if (flush) begin
        out_valid_q <= 1'b0;
      end else if (in_ready) begin
        out_valid_q <= in_valid;
        if (in_valid) out_q <= dec;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_opcode  = out_q.opcode;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_use_rs1 = out_q.use_rs1;
  assign out_use_rs2 = out_q.use_rs2;
  assign out_use_rd  = out_q.use_rd;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Two decode_stage instances share one input stream:
//     dut0: XLEN=32, ENABLE_RV64=0, SKID=1
//     dut1: XLEN=64, ENABLE_RV64=1, SKID=0
//   The driver pushes the expected decode of every accepted word into a
//   per-instance queue; a separate monitor compares out_* against the queue
//   head every cycle and pops on output transfer. Flush empties the queues.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        u1;
    logic        u2;
    logic        ud;
    logic        ill;
  } item_t;

  item_t q0[$];
  item_t q1[$];
  int    n_chk = 0;
  int    n_fail = 0;

  // ---------------- dut0 ----------------
  logic        rdy0, ov0, u10, u20, ud0, ill0;
  logic [31:0] pc0, imm0;
  logic [6:0]  op0, f70;
  logic [4:0]  rd0, rs10, rs20;
  logic [2:0]  f30, fmt0;

  decode_stage #(.XLEN(32), .ENABLE_RV64(1'b0), .SKID(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(ov0), .out_ready(out_ready), .out_pc(pc0), .out_opcode(op0),
    .out_rd(rd0), .out_rs1(rs10), .out_rs2(rs20), .out_funct3(f30), .out_funct7(f70),
    .out_imm(imm0), .out_fmt(fmt0), .out_use_rs1(u10), .out_use_rs2(u20),
    .out_use_rd(ud0), .out_illegal(ill0)
  );

  // ---------------- dut1 ----------------
  logic        rdy1, ov1, u11, u21, ud1, ill1;
  logic [63:0] pc1, imm1;
  logic [6:0]  op1, f71;
  logic [4:0]  rd1, rs11, rs21;
  logic [2:0]  f31, fmt1;

  decode_stage #(.XLEN(64), .ENABLE_RV64(1'b1), .SKID(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(ov1), .out_ready(out_ready), .out_pc(pc1), .out_opcode(op1),
    .out_rd(rd1), .out_rs1(rs11), .out_rs2(rs21), .out_funct3(f31), .out_funct7(f71),
    .out_imm(imm1), .out_fmt(fmt1), .out_use_rs1(u11), .out_use_rs2(u21),
    .out_use_rd(ud1), .out_illegal(ill1)
  );

  item_t act0, act1;
  always_comb begin
    act0 = '0;
    act0.pc = {32'b0, pc0}; act0.opcode = op0; act0.rd = rd0; act0.rs1 = rs10;
    act0.rs2 = rs20; act0.f3 = f30; act0.f7 = f70; act0.imm = {32'b0, imm0};
    act0.fmt = fmt0; act0.u1 = u10; act0.u2 = u20; act0.ud = ud0; act0.ill = ill0;
  end
  always_comb begin
    act1 = '0;
    act1.pc = pc1; act1.opcode = op1; act1.rd = rd1; act1.rs1 = rs11;
    act1.rs2 = rs21; act1.f3 = f31; act1.f7 = f71; act1.imm = imm1;
    act1.fmt = fmt1; act1.u1 = u11; act1.u2 = u21; act1.ud = ud1; act1.ill = ill1;
  end

  // ---------------- reference model ----------------
  // Format codes: 0=R 1=I 2=S 3=B 4=U 5=J 6=NONE. Immediates are computed as
  // signed integers; a 32-bit datapath sees the low 32 bits.
  function automatic item_t model(input logic [31:0] i, input logic [63:0] pc,
                                  input bit wide, input bit rv64);
    item_t  e;
    int     f;
    longint imm;
    e = '0;
    e.opcode = i[6:0];
    e.pc = wide ? pc : {32'b0, pc[31:0]};
    f = 6;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h33:                      f = 0;
        7'h3B:                      f = rv64 ? 0 : 6;
        7'h13, 7'h03, 7'h67, 7'h73: f = 1;
        7'h1B:                      f = rv64 ? 1 : 6;
        7'h23:                      f = 2;
        7'h63:                      f = 3;
        7'h37, 7'h17:               f = 4;
        7'h6F:                      f = 5;
        default:                    f = 6;
      endcase
    end
    e.fmt = 3'(f);
    e.ill = (f == 6);
    if (!e.ill) begin
      case (f)
        1: imm = longint'($signed(i[31:20]));
        2: imm = longint'($signed({i[31:25], i[11:7]}));
        3: imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        4: imm = longint'($signed(i[31:12])) * 4096;
        5: imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        default: imm = 0;
      endcase
      e.imm = wide ? 64'(imm) : {32'b0, imm[31:0]};
      if (f == 0 || f == 1 || f == 4 || f == 5) begin
        e.rd = i[11:7];
        e.ud = (i[11:7] != 5'd0);
      end
      if (f <= 3) begin
        e.rs1 = i[19:15];
        e.f3  = i[14:12];
        e.u1  = 1'b1;
      end
      if (f == 0 || f == 2 || f == 3) begin
        e.rs2 = i[24:20];
        e.u2  = 1'b1;
      end
      if (f == 0) e.f7 = i[31:25];
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [13] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                              7'h37, 7'h17, 7'h6F, 7'h3B, 7'h1B, 7'h00};
    logic [31:0] r;
    int          s;
    r = $urandom;
    s = $urandom_range(0, 12);
    r[6:0] = (s == 12) ? 7'($urandom) : ops[s];
    if ($urandom_range(0, 9) == 0) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive at negedge; +1 check in_ready against model occupancy; +3 update
  // the scoreboard (the monitor samples at +2, before new pushes).
  task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                       input logic ordy, input logic fl, output logic f0);
    logic f1;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    chk("dut0 in_ready", rdy0, q0.size() < 2);
    chk("dut1 in_ready", rdy1, q1.size() == 0 || ordy);
    f0 = v && rdy0;
    f1 = v && rdy1;
    #2;
    if (fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (f0) q0.push_back(model(ins, pc, 1'b0, 1'b0));
      if (f1) q1.push_back(model(ins, pc, 1'b1, 1'b1));
    end
  endtask

  // ---------------- monitor ----------------
  task automatic mon_one(input int k, input logic ov, input item_t a);
    int    sz;
    item_t e;
    sz = (k == 0) ? q0.size() : q1.size();
    chk($sformatf("dut%0d out_valid", k), ov, sz != 0);
    if (ov && sz != 0) begin
      e = (k == 0) ? q0[0] : q1[0];
      chk($sformatf("dut%0d out item", k), a, e);
      if (out_ready) begin
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && !flush) begin
      mon_one(0, ov0, act0);
      mon_one(1, ov1, act1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] stream [4] = '{32'h00100113, 32'h00208193, 32'h00310223, 32'h004182B3};
  logic        fire;
  int          n_acc;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset dut0 out_valid", ov0, 1'b0);
    chk("reset dut1 out_valid", ov1, 1'b0);
    chk("reset dut0 in_ready", rdy0, 1'b1);
    chk("reset dut1 in_ready", rdy1, 1'b1);
    chk("reset dut0 out_pc", pc0, 32'h0);
    chk("reset dut1 out_imm", imm1, 64'h0);

    // addi x1,x0,5
    drive(1'b1, 32'h00500093, 64'h1000, 1'b1, 1'b0, fire);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, fire);
    chk("addi out_valid", ov0, 1'b1);
    chk("addi fmt", fmt0, 3'd1);
    chk("addi rd", rd0, 5'd1);
    chk("addi rs1", rs10, 5'd0);
    chk("addi imm", imm0, 32'd5);
    chk("addi use_rd", ud0, 1'b1);
    chk("addi use_rs2", u20, 1'b0);

    // bne x1,x2,-4
    drive(1'b1, 32'hFE209EE3, 64'h1004, 1'b1, 1'b0, fire);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, fire);
    chk("bne fmt", fmt0, 3'd3);
    chk("bne rd", rd0, 5'd0);
    chk("bne rs1/rs2", {rs10, rs20}, {5'd1, 5'd2});
    chk("bne imm32", imm0, 32'hFFFF_FFFC);
    chk("bne imm64", imm1, 64'hFFFF_FFFF_FFFF_FFFC);

    // lui x1,0x80000
    drive(1'b1, 32'h800000B7, 64'h1008, 1'b1, 1'b0, fire);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, fire);
    chk("lui fmt", fmt1, 3'd4);
    chk("lui imm64", imm1, 64'hFFFF_FFFF_8000_0000);
    chk("lui imm32", imm0, 32'h8000_0000);

    // OP-IMM-32 word: illegal without RV64, I-type with it
    drive(1'b1, 32'h0000001B, 64'h100C, 1'b1, 1'b0, fire);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, fire);
    chk("rv64 op illegal", ill0, 1'b1);
    chk("rv64 op fmt none", fmt0, 3'd6);
    chk("rv64 op imm zero", imm0, 32'h0);
    chk("rv64 op legal on rv64", {ill1, fmt1}, {1'b0, 3'd1});

    // all-zero word: low bits 00
    drive(1'b1, 32'h00000000, 64'h1010, 1'b1, 1'b0, fire);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, fire);
    chk("zero word illegal", {ill0, ill1}, 2'b11);

    // four-word stream with execute stalled in cycles 2..4
    n_acc = 0;
    for (int c = 1; c <= 20 && n_acc < 4; c++) begin
      drive(1'b1, stream[n_acc], 64'h2000 + 64'(n_acc * 4), !(c >= 2 && c <= 4), 1'b0, fire);
      if (c == 3) chk("skid full in_ready", rdy0, 1'b0);
      if (fire) n_acc++;
    end
    chk("stream accepted", n_acc, 4);
    repeat (4) drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, fire);
    chk("stream drained dut0", q0.size(), 0);

    // fill output + skid, then flush with a new word handshaking
    for (int c = 0; c < 3; c++)
      drive(1'b1, 32'h00A00513 + 32'(c << 20), 64'h3000 + 64'(c * 4), 1'b0, 1'b0, fire);
    drive(1'b1, 32'h00B00593, 64'h300C, 1'b0, 1'b1, fire);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, fire);
    chk("flush out_valid", {ov0, ov1}, 2'b00);
    chk("flush in_ready", {rdy0, rdy1}, 2'b11);
    repeat (3) drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, fire);

    // randomized traffic
    for (int c = 0; c < 1000; c++)
      drive($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, fire);

    repeat (6) drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, fire);
    chk("final drain dut0", q0.size(), 0);
    chk("final drain dut1", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
